// File: rtl/inv_mix_columns_serial.sv
`default_nettype none
// ============================================================================
// Module      : inv_mix_columns_serial
// Description : Byte-serial AES InvMixColumns stage. Collects four bytes of a
//               state column, multiplies the column by the inverse MixColumns
//               matrix over GF(2^8) and streams the four result bytes out in
//               order. A four-byte result buffer sustains 1 byte/cycle with
//               no output gaps.
// Ports       : clock     - rising-edge clock
//               reset     - synchronous active-high reset
//               inbyte    - input state byte, column-major order
//               in_valid  - inbyte is accepted on every edge it is high
//               bypass    - (INV_MIX_BYPASS_EN) identity transform for the
//                           block whose byte 0 samples it high
//               outbyte   - registered result byte
//               out_valid - outbyte carries a result this cycle
//               out_last  - final byte (BLOCK_BYTES-1) of a state
// Options     : `define INV_MIX_BYPASS_EN adds the bypass port.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_mix_columns_serial #(
  parameter int BLOCK_BYTES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] inbyte,
  input  logic       in_valid,
`ifdef INV_MIX_BYPASS_EN
  input  logic       bypass,
`endif
  output logic [7:0] outbyte,
  output logic       out_valid,
  output logic       out_last
);

  localparam int c_CNT_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {C0 = 2'd0, C1 = 2'd1, C2 = 2'd2, C3 = 2'd3} col_state_t;
  typedef enum logic [2:0] {
    OIDLE = 3'd0, O0 = 3'd1, O1 = 3'd2, O2 = 3'd3, O3 = 3'd4
  } out_state_t;

  // --------------------------------------------------------------------------
  // GF(2^8) constant multipliers built from xtime chains (poly 0x11B)
  // --------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul09(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b); x4 = xtime(x2); x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0b(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b); x4 = xtime(x2); x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0d(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b); x4 = xtime(x2); x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b); x4 = xtime(x2); x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  col_state_t        r_cstate, w_cstate_nxt;
  out_state_t        r_ostate, w_ostate_nxt;
  logic [7:0]        r_a0, r_a1, r_a2;
  logic [7:0]        r_res0, r_res1, r_res2, r_res3;
  logic [c_CNT_W-1:0] r_count;

  logic       w_complete;
  logic       w_emit;
  logic       w_use_bypass;
  logic [7:0] w_r0, w_r1, w_r2, w_r3;
  logic [7:0] w_sel;

  // The 4th byte is used straight from inbyte so the result is ready on the
  // same edge that accepts it.
  assign w_complete = in_valid && (r_cstate == C3);
  assign w_emit     = (r_ostate != OIDLE);

`ifdef INV_MIX_BYPASS_EN
  logic               r_bypass;
  logic [c_CNT_W-1:0] r_in_idx;

  // Bypass is latched with byte 0 of each block; the first column completes
  // three accepts later, so it already sees the latched value.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bypass <= 1'b0;
      r_in_idx <= '0;
    end else if (in_valid) begin
      if (r_in_idx == '0) begin
        r_bypass <= bypass;
      end
      r_in_idx <= (r_in_idx == c_LAST) ? '0 : r_in_idx + 1'b1;
    end
  end

  assign w_use_bypass = r_bypass;
`else
  assign w_use_bypass = 1'b0;
`endif

  always_comb begin
    if (w_use_bypass) begin
      w_r0 = r_a0;
      w_r1 = r_a1;
      w_r2 = r_a2;
      w_r3 = inbyte;
    end else begin
      w_r0 = gf_mul0e(r_a0) ^ gf_mul0b(r_a1) ^ gf_mul0d(r_a2) ^ gf_mul09(inbyte);
      w_r1 = gf_mul09(r_a0) ^ gf_mul0e(r_a1) ^ gf_mul0b(r_a2) ^ gf_mul0d(inbyte);
      w_r2 = gf_mul0d(r_a0) ^ gf_mul09(r_a1) ^ gf_mul0e(r_a2) ^ gf_mul0b(inbyte);
      w_r3 = gf_mul0b(r_a0) ^ gf_mul0d(r_a1) ^ gf_mul09(r_a2) ^ gf_mul0e(inbyte);
    end
  end

  // --------------------------------------------------------------------------
  // FSM state registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cstate <= C0;
      r_ostate <= OIDLE;
    end else begin
      r_cstate <= w_cstate_nxt;
      r_ostate <= w_ostate_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_cstate_nxt = r_cstate;
    w_ostate_nxt = r_ostate;
    w_sel        = r_res0;

    if (in_valid) begin
      case (r_cstate)
        C0:      w_cstate_nxt = C1;
        C1:      w_cstate_nxt = C2;
        C2:      w_cstate_nxt = C3;
        default: w_cstate_nxt = C0;
      endcase
    end

    // A completion always restarts the sequence; back-to-back columns land
    // exactly on the O3 cycle, so the old r3 is emitted while res reloads.
    if (w_complete) begin
      w_ostate_nxt = O0;
    end else begin
      case (r_ostate)
        O0:      w_ostate_nxt = O1;
        O1:      w_ostate_nxt = O2;
        O2:      w_ostate_nxt = O3;
        default: w_ostate_nxt = OIDLE;
      endcase
    end

    case (r_ostate)
      O1:      w_sel = r_res1;
      O2:      w_sel = r_res2;
      O3:      w_sel = r_res3;
      default: w_sel = r_res0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_a0      <= 8'h00;
      r_a1      <= 8'h00;
      r_a2      <= 8'h00;
      r_res0    <= 8'h00;
      r_res1    <= 8'h00;
      r_res2    <= 8'h00;
      r_res3    <= 8'h00;
      r_count   <= '0;
      outbyte   <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (in_valid) begin
        case (r_cstate)
          C0:      r_a0 <= inbyte;
          C1:      r_a1 <= inbyte;
          C2:      r_a2 <= inbyte;
          default: ;
        endcase
      end

      if (w_complete) begin
        r_res0 <= w_r0;
        r_res1 <= w_r1;
        r_res2 <= w_r2;
        r_res3 <= w_r3;
      end

      out_valid <= w_emit;
      if (w_emit) begin
        outbyte  <= w_sel;
        out_last <= (r_count == c_LAST);
        r_count  <= (r_count == c_LAST) ? '0 : r_count + 1'b1;
      end else begin
        out_last <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
